// File: rtl/addsub_pkg.sv
// Shared types and helpers for the adder/subtractor result accumulator.
// Saturating accumulation is selected with ADDSUB_RESULT_ACC_SATURATE_EN.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 32;

    // Signed overflow: operands agree in sign but the result does not.
    function automatic logic ovf_detect(
        input logic a_sign,
        input logic b_sign,
        input logic r_sign
    );
        return (a_sign == b_sign) && (r_sign != a_sign);
    endfunction

endpackage

// File: rtl/addsub_acc_adder.sv
// Combinational accumulator adder with signed overflow detection.
// Clamps on overflow when ADDSUB_RESULT_ACC_SATURATE_EN is defined.
module addsub_acc_adder
    import addsub_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int ACC_WIDTH = 40
) (
    input  logic [ACC_WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]     sum_i,
    output logic [ACC_WIDTH-1:0] res_o,
    output logic                 ovf_o
);

    localparam int MSB = ACC_WIDTH - 1;

    logic [ACC_WIDTH-1:0] b_ext;
    logic [ACC_WIDTH-1:0] raw;

    always_comb begin
        b_ext = ACC_WIDTH'($signed(sum_i));
        raw   = acc_i + b_ext;
        ovf_o = ovf_detect(acc_i[MSB], b_ext[MSB], raw[MSB]);
`ifdef ADDSUB_RESULT_ACC_SATURATE_EN
        // Operand sign picks the rail the wrapped result overshot.
        if (ovf_o) begin
            if (acc_i[MSB]) begin
                res_o = {1'b1, {(ACC_WIDTH-1){1'b0}}};
            end else begin
                res_o = {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end
        end else begin
            res_o = raw;
        end
`else
        res_o = raw;
`endif
    end

endmodule

// File: rtl/addsub_result_acc.sv
// Burst accumulator for the adder/subtractor result stream.
// Optional clamping arithmetic: define ADDSUB_RESULT_ACC_SATURATE_EN.
module addsub_result_acc
    import addsub_pkg::*;
#(
    parameter int  WIDTH     = DEFAULT_WIDTH,
    parameter int  ACC_WIDTH = 40,
    parameter int  BURST_LEN = 4,
    localparam int CW        = $clog2(BURST_LEN + 1)
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 CLR,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [WIDTH-1:0]     SUM,
    input  logic                 MODE,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [ACC_WIDTH-1:0] ACC,
    output logic [CW-1:0]        SUB_CNT,
    output logic                 OVF
);

    state_e               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]        sub_q, sub_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;

    logic [ACC_WIDTH-1:0] add_res;
    logic                 add_ovf;
    logic                 accept;

    addsub_acc_adder #(
        .WIDTH    (WIDTH),
        .ACC_WIDTH(ACC_WIDTH)
    ) u_adder (
        .acc_i(acc_q),
        .sum_i(SUM),
        .res_o(add_res),
        .ovf_o(add_ovf)
    );

    assign IN_READY  = (state_q != EMIT) && !CLR;
    assign OUT_VALID = (state_q == EMIT);
    assign accept    = IN_VALID && IN_READY;

    assign ACC     = acc_q;
    assign SUB_CNT = sub_q;
    assign OVF     = ovf_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        sub_d   = sub_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (CLR) begin
            state_d = IDLE;
            acc_d   = '0;
            sub_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc_d = add_res;
                        sub_d = sub_q + CW'(MODE);
                        ovf_d = ovf_q | add_ovf;
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_d == CW'(BURST_LEN)) begin
                            state_d = EMIT;
                        end else begin
                            state_d = ACCUM;
                        end
                    end
                end
                EMIT: begin
                    // Drain completes a cycle later; no bypass into a new burst.
                    if (OUT_READY) begin
                        state_d = IDLE;
                        acc_d   = '0;
                        sub_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    sub_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            acc_q   <= '0;
            sub_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            sub_q   <= sub_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_addsub_result_acc.sv
// Bench for addsub_result_acc: default, 32-bit accumulator and single-beat builds.
module tb_addsub_result_acc;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    logic CLR = 1'b0;

    logic [2:0]       iv;
    logic [2:0]       mode;
    logic [2:0]       ordy;
    logic [2:0][31:0] sum;
    logic [2:0]       irdy;
    logic [2:0]       ovld;
    logic [2:0]       ovf;
    logic [2:0][39:0] acc;
    logic [2:0][2:0]  sc;

    logic [31:0] acc_b;
    logic [2:0]  sc_a;
    logic [2:0]  sc_b;
    logic [39:0] acc_a;
    logic [39:0] acc_c;
    logic        sc_c;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    addsub_result_acc u_dut_a (
        .CLK(CLK), .RST_N(RST_N), .CLR(CLR),
        .IN_VALID(iv[0]), .IN_READY(irdy[0]),
        .SUM(sum[0]), .MODE(mode[0]),
        .OUT_VALID(ovld[0]), .OUT_READY(ordy[0]),
        .ACC(acc_a), .SUB_CNT(sc_a), .OVF(ovf[0])
    );

    addsub_result_acc #(.ACC_WIDTH(32)) u_dut_b (
        .CLK(CLK), .RST_N(RST_N), .CLR(CLR),
        .IN_VALID(iv[1]), .IN_READY(irdy[1]),
        .SUM(sum[1]), .MODE(mode[1]),
        .OUT_VALID(ovld[1]), .OUT_READY(ordy[1]),
        .ACC(acc_b), .SUB_CNT(sc_b), .OVF(ovf[1])
    );

    addsub_result_acc #(.BURST_LEN(1)) u_dut_c (
        .CLK(CLK), .RST_N(RST_N), .CLR(CLR),
        .IN_VALID(iv[2]), .IN_READY(irdy[2]),
        .SUM(sum[2]), .MODE(mode[2]),
        .OUT_VALID(ovld[2]), .OUT_READY(ordy[2]),
        .ACC(acc_c), .SUB_CNT(sc_c), .OVF(ovf[2])
    );

    assign acc[0] = acc_a;
    assign acc[1] = {{8{acc_b[31]}}, acc_b};
    assign acc[2] = acc_c;
    assign sc[0]  = sc_a;
    assign sc[1]  = sc_b;
    assign sc[2]  = {2'b00, sc_c};

    typedef struct {
        logic [31:0] s [4];
        bit          m [4];
        logic [39:0] exp_acc;
        int          exp_sub;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer running total against the signed range.
    function automatic longint ref_total(input int aw, input longint v[$],
                                         output bit o);
        longint hi;
        longint lo;
        longint a;
        hi = (longint'(1) <<< (aw - 1)) - 1;
        lo = -(longint'(1) <<< (aw - 1));
        a  = 0;
        o  = 1'b0;
        foreach (v[k]) begin
            a = a + v[k];
            if (a > hi || a < lo) begin
                o = 1'b1;
`ifdef ADDSUB_RESULT_ACC_SATURATE_EN
                a = (a > hi) ? hi : lo;
`else
                a = (a > hi) ? a - (longint'(1) <<< aw)
                             : a + (longint'(1) <<< aw);
`endif
            end
        end
        return a;
    endfunction

    // Offers nb beats, each accepted on the next edge; returns at the
    // negedge following the final accept.
    task automatic burst(input int i, input int nb,
                         input logic [31:0] s [4], input bit m [4]);
        for (int k = 0; k < nb; k++) begin
            iv[i]   = 1'b1;
            sum[i]  = s[k];
            mode[i] = m[k];
            #1;
            chk($sformatf("beat_ready%0d_%0d", i, k), 64'(irdy[i]), 64'd1);
            @(negedge CLK);
        end
        iv[i] = 1'b0;
    endtask

    task automatic chk_out(input string nm, input int i, input bit v,
                           input bit r, input logic [39:0] a,
                           input int s, input bit o);
        chk({nm, "_valid"}, 64'(ovld[i]), 64'(v));
        chk({nm, "_ready"}, 64'(irdy[i]), 64'(r));
        chk({nm, "_acc"},   64'(acc[i]),  64'(a));
        chk({nm, "_sub"},   64'(sc[i]),   64'(s));
        chk({nm, "_ovf"},   64'(ovf[i]),  64'(o));
    endtask

    logic [31:0] bs [4];
    bit          bm [4];
    longint      q [$];
    longint      ea;
    bit          eo;
    int          esub;
    bit          emitting;

    initial begin
        iv = '0; mode = '0; ordy = '0; sum = '0;

        tbl[0].s = '{32'd10, 32'd20, 32'hFFFFFFFB, 32'd7};
        tbl[0].m = '{0, 0, 1, 0};
        tbl[0].exp_acc = 40'd32;           tbl[0].exp_sub = 1;
        tbl[1].s = '{32'd1, 32'd1, 32'd1, 32'd1};
        tbl[1].m = '{0, 0, 0, 0};
        tbl[1].exp_acc = 40'd4;            tbl[1].exp_sub = 0;
        tbl[2].s = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFC};
        tbl[2].m = '{1, 1, 1, 1};
        tbl[2].exp_acc = 40'hFFFFFFFFF6;   tbl[2].exp_sub = 4;
        tbl[3].s = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000};
        tbl[3].m = '{0, 1, 0, 1};
        tbl[3].exp_acc = 40'hFE00000000;   tbl[3].exp_sub = 2;
        tbl[4].s = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF};
        tbl[4].m = '{1, 0, 0, 0};
        tbl[4].exp_acc = 40'h01FFFFFFFC;   tbl[4].exp_sub = 1;
        tbl[5].s = '{32'd100, 32'hFFFFFF9C, 32'd50, 32'hFFFFFFCD};
        tbl[5].m = '{0, 1, 1, 0};
        tbl[5].exp_acc = 40'hFFFFFFFFFF;   tbl[5].exp_sub = 2;

        repeat (2) @(negedge CLK);
        chk("rst_valid", 64'(ovld[0]), 64'd0);
        chk("rst_acc",   64'(acc[0]),  64'd0);
        chk("rst_sub",   64'(sc[0]),   64'd0);
        chk("rst_ovf",   64'(ovf[0]),  64'd0);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("rst_ready", 64'(irdy[0]), 64'd1);

        // Table bursts, consumer always ready.
        ordy[0] = 1'b1;
        for (int r = 0; r < 6; r++) begin
            burst(0, 4, tbl[r].s, tbl[r].m);
            chk_out($sformatf("tbl%0d_emit", r), 0, 1'b1, 1'b0,
                    tbl[r].exp_acc, tbl[r].exp_sub, 1'b0);
            @(negedge CLK);
            chk_out($sformatf("tbl%0d_drain", r), 0, 1'b0, 1'b1,
                    40'd0, 0, 1'b0);
        end

        // Backpressure with a beat waiting.
        ordy[0] = 1'b0;
        bs = '{32'd3, 32'd4, 32'd5, 32'd6};
        bm = '{0, 0, 0, 0};
        burst(0, 4, bs, bm);
        iv[0] = 1'b1; sum[0] = 32'd99;
        for (int k = 0; k < 5; k++) begin
            chk_out($sformatf("bp%0d", k), 0, 1'b1, 1'b0, 40'd18, 0, 1'b0);
            @(negedge CLK);
        end
        iv[0] = 1'b0; ordy[0] = 1'b1;
        @(negedge CLK);
        chk_out("bp_drain", 0, 1'b0, 1'b1, 40'd0, 0, 1'b0);
        bs = '{32'd1, 32'd1, 32'd1, 32'd1};
        burst(0, 4, bs, bm);
        chk_out("bp_next", 0, 1'b1, 1'b0, 40'd4, 0, 1'b0);
        @(negedge CLK);

        // 32-bit accumulator overflow, then a clean burst.
        ordy[1] = 1'b1;
        bs = '{32'h7FFFFFFF, 32'd1, 32'd0, 32'd0};
        burst(1, 4, bs, bm);
`ifdef ADDSUB_RESULT_ACC_SATURATE_EN
        chk_out("ovf_emit", 1, 1'b1, 1'b0, 40'h007FFFFFFF, 0, 1'b1);
`else
        chk_out("ovf_emit", 1, 1'b1, 1'b0, 40'hFF80000000, 0, 1'b1);
`endif
        @(negedge CLK);
        bs = '{32'd1, 32'd2, 32'd3, 32'd4};
        burst(1, 4, bs, bm);
        chk_out("ovf_next", 1, 1'b1, 1'b0, 40'd10, 0, 1'b0);
        @(negedge CLK);

        // Clear after two beats, with a beat offered during the clear.
        bs = '{32'd5, 32'd6, 32'd0, 32'd0};
        bm = '{1, 0, 0, 0};
        burst(0, 2, bs, bm);
        chk_out("clr_partial", 0, 1'b0, 1'b1, 40'd11, 1, 1'b0);
        CLR = 1'b1; iv[0] = 1'b1; sum[0] = 32'd100;
        #1;
        chk("clr_ready", 64'(irdy[0]), 64'd0);
        @(negedge CLK);
        CLR = 1'b0; iv[0] = 1'b0;
        #1;
        chk_out("clr_after", 0, 1'b0, 1'b1, 40'd0, 0, 1'b0);
        bs = '{32'd2, 32'd2, 32'd2, 32'd2};
        bm = '{0, 0, 0, 0};
        burst(0, 4, bs, bm);
        chk_out("clr_next", 0, 1'b1, 1'b0, 40'd8, 0, 1'b0);
        @(negedge CLK);

        // Asynchronous reset while holding an overflowed result.
        ordy[1] = 1'b0;
        bs = '{32'h7FFFFFFF, 32'd1, 32'd0, 32'd0};
        burst(1, 4, bs, bm);
        chk("arst_pre_valid", 64'(ovld[1]), 64'd1);
        #1 RST_N = 1'b0;
        #1;
        chk("arst_valid", 64'(ovld[1]), 64'd0);
        chk("arst_acc",   64'(acc[1]),  64'd0);
        chk("arst_ovf",   64'(ovf[1]),  64'd0);
        #1 RST_N = 1'b1;
        @(negedge CLK);
        chk("arst_ready", 64'(irdy[1]), 64'd1);
        chk("arst_valid2", 64'(ovld[1]), 64'd0);
        ordy[1] = 1'b1;

        // Single-beat bursts with IN_VALID held high.
        ordy[2] = 1'b1; iv[2] = 1'b1; mode[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sum[2] = 32'(3 + k);
            #1;
            chk($sformatf("b1_idle%0d_valid", k), 64'(ovld[2]), 64'd0);
            chk($sformatf("b1_idle%0d_ready", k), 64'(irdy[2]), 64'd1);
            @(negedge CLK);
            chk($sformatf("b1_emit%0d_valid", k), 64'(ovld[2]), 64'd1);
            chk($sformatf("b1_emit%0d_acc", k),   64'(acc[2]), 64'(3 + k));
            chk($sformatf("b1_emit%0d_ready", k), 64'(irdy[2]), 64'd0);
            @(negedge CLK);
        end
        iv[2] = 1'b0;

        // Random traffic on the default build against the reference model.
        q.delete();
        esub = 0;
        emitting = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            ea = ref_total(40, q, eo);
            chk_out($sformatf("rnd%0d", cyc), 0, emitting,
                    !emitting && !CLR, ea[39:0], esub, eo);
            CLR     = ($urandom_range(0, 24) == 0);
            iv[0]   = ($urandom_range(0, 3) != 0);
            sum[0]  = $urandom;
            mode[0] = $urandom_range(0, 1) == 1;
            ordy[0] = ($urandom_range(0, 2) != 0);
            if (CLR) begin
                q.delete();
                esub = 0;
                emitting = 1'b0;
            end else if (emitting) begin
                if (ordy[0]) begin
                    q.delete();
                    esub = 0;
                    emitting = 1'b0;
                end
            end else if (iv[0]) begin
                q.push_back(longint'($signed(sum[0])));
                esub += int'(mode[0]);
                if (q.size() == 4) emitting = 1'b1;
            end
            @(negedge CLK);
        end
        CLR = 1'b0;
        iv[0] = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/addsub_result_acc.md
Name: addsub_result_acc

Overview:
- Downstream consumer of the 32-bit adder/subtractor result stream.
- Accepts SUM/MODE beats over a valid/ready handshake and accumulates BURST_LEN signed results into a wider accumulator.
- Presents the burst total, a subtract-count and an overflow flag on an output valid/ready handshake.
- Feeds the checker/scoreboard stage and any block needing batched results.

Parameters:
- WIDTH, 32: width of SUM (two's complement).
- ACC_WIDTH, 40: accumulator width. Must be >= WIDTH.
- BURST_LEN, 4: results per burst. Must be >= 1.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- CLR  input  1  synchronous clear; highest priority after reset.
- IN_VALID  input  1  SUM/MODE beat valid.
- IN_READY  output  1  block can accept a beat.
- SUM  input  WIDTH  signed result from adder/subtractor.
- MODE  input  1  operation tag of the beat (1 = subtract).
- OUT_VALID  output  1  burst result valid.
- OUT_READY  input  1  consumer accepts the result.
- ACC  output  ACC_WIDTH  signed burst total.
- SUB_CNT  output  $clog2(BURST_LEN+1)  number of MODE=1 beats in the burst.
- OVF  output  1  sticky signed overflow within the burst.

Behaviour:
- Reset, asynchronous on RST_N low: state IDLE, OUT_VALID=0, ACC=0, SUB_CNT=0, OVF=0, beat counter=0. IN_READY=1 from the first cycle after RST_N rises.
- FSM states:
  - IDLE: counter=0.
  - ACCUM: 0 < counter < BURST_LEN.
  - EMIT: result held.
- Accept condition: IN_VALID && IN_READY on a rising CLK edge.
- IN_READY = (state != EMIT) && !CLR. Combinational from registered state only; no path from IN_VALID.
- On accept:
  - ACC <= ACC + sign-extended SUM.
  - SUB_CNT += MODE.
  - counter += 1.
  - OVF |= signed overflow of the ACC_WIDTH add.
- IDLE -> ACCUM on accept when BURST_LEN > 1. ACCUM stays until the BURST_LEN-th accept.
- On the BURST_LEN-th accept -> EMIT. OUT_VALID=1 on the following cycle (latency 1 from last beat), with the final ACC/SUB_CNT/OVF.
- BURST_LEN=1: IDLE -> EMIT directly on each accept.
- EMIT:
  - ACC, SUB_CNT and OVF are stable while OUT_VALID && !OUT_READY.
  - No beats are accepted.
  - On OUT_VALID && OUT_READY: next cycle ACC=0, SUB_CNT=0, OVF=0, counter=0, state IDLE, OUT_VALID=0.
  - No same-cycle bypass: throughput is at most one burst per BURST_LEN+1 cycles.
- Arithmetic: wrap modulo 2^ACC_WIDTH (default build). Overflow = operands of equal sign and result of differing sign.
- CLR high on an edge, in any state (including EMIT with OUT_VALID=1): returns to IDLE with all outputs at reset values. A beat presented that cycle is not accepted (IN_READY=0).
- RST_N asserted mid-burst or mid-EMIT: immediate asynchronous clear. OUT_VALID drops without waiting for a clock.
- ACC, SUB_CNT and OVF are registered. Their values are don't-care-free: they always reflect the in-progress partial burst.

Optional Feature:
- Macro: ADDSUB_RESULT_ACC_SATURATE_EN.
- Defined: on signed overflow the accumulator clamps to 2^(ACC_WIDTH-1)-1 (positive) or -2^(ACC_WIDTH-1) (negative). Later beats continue from the clamped value. OVF is set on any clamp.
- Undefined: wrap-around arithmetic as above. OVF is still set.

Decomposition:
- Package addsub_pkg:
  - state_e enum {IDLE, ACCUM, EMIT}.
  - localparam DEFAULT_WIDTH=32.
  - Function ovf_detect(a_sign, b_sign, r_sign).
- One sub-module: addsub_acc_adder.
  - Combinational ACC_WIDTH signed add with overflow output.
  - Contains the saturation clamp under the macro.
  - The FSM, counter and handshake stay in the top.

Test Plan:
1. Defaults. Beats 10, 20, -5, 7 with MODE 0, 0, 1, 0, OUT_READY=1 -> OUT_VALID 1 cycle after 4th accept, ACC=32, SUB_CNT=1, OVF=0. IN_READY=0 for exactly 1 cycle.
2. Backpressure. OUT_READY=0 for 5 cycles while IN_VALID=1 -> ACC/SUB_CNT stable, IN_READY=0, no beats consumed. After the handshake, the next burst 1, 1, 1, 1 -> ACC=4.
3. Overflow, ACC_WIDTH=32. Beats 0x7FFFFFFF, 1, 0, 0 -> without macro ACC=0x80000000, OVF=1. With macro ACC=0x7FFFFFFF, OVF=1. Following burst has OVF=0.
4. CLR after 2 accepted beats (5, 6), held 1 cycle with IN_VALID=1 -> that beat is not accepted. Next beats 2, 2, 2, 2 -> ACC=8, SUB_CNT=0.
5. RST_N low asynchronously mid-cycle during EMIT -> OUT_VALID, ACC, OVF go to 0 before the next CLK edge. IN_READY=1 after release.
6. BURST_LEN=1, IN_VALID held high, OUT_READY=1, SUM=3, 4, 5 -> OUT_VALID every other cycle with ACC=3, 4, 5 in order.
